sram_march_bist: RTL

SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

---
 rtl/sram_march_bist.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sram_march_bist.sv
// sram_march_bist: March C- BIST controller for a synchronous single-port SRAM.
// Optional feature macro SRAM_BIST_STOP_ON_FAIL_EN: end the run on the edge that captures the first mismatch.
module sram_march_bist #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  sram_we,
    output logic                  sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

    state_t                state, state_n;
    logic [2:0]            elem, elem_n;
    logic                  ph, ph_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic                  go, two_op, down, elem_end, last_op, we_n, dbit_n, issue;
    logic                  pv, mismatch, first_fail;
    logic [DATA_WIDTH-1:0] pexp;
    logic [ADDR_WIDTH-1:0] paddr;

    assign busy = state == RUN || state == FLUSH;
    assign done = state == DONE;

    // Next op: the op on the SRAM outputs (elem, ph, sram_addr) advances to the next one in March order
    always_comb begin
        go       = start && (state == IDLE || state == DONE);
        two_op   = elem >= 3'd1 && elem <= 3'd4;
        down     = elem == 3'd3 || elem == 3'd4;
        elem_end = down ? sram_addr == '0 : sram_addr == LAST;
        last_op  = elem == 3'd5 && sram_addr == LAST;
        elem_n   = elem;
        ph_n     = 1'b0;
        addr_n   = sram_addr;
        if (go) begin
            elem_n = 3'd0;
            addr_n = '0;
        end else if (two_op && !ph) begin
            ph_n = 1'b1;
        end else if (elem_end) begin
            elem_n = elem + 3'd1;
            addr_n = (elem == 3'd2 || elem == 3'd3) ? LAST : '0;
        end else begin
            addr_n = down ? sram_addr - ONE : sram_addr + ONE;
        end
        we_n   = elem_n == 3'd0 || ph_n;
        dbit_n = elem_n >= 3'd1 && elem_n <= 3'd4 && (ph_n ^ ~elem_n[0]);
    end

    // Controller FSM next state; the first mismatch may cut the run short
    always_comb begin
        mismatch   = pv && busy && sram_dout != pexp;
        first_fail = mismatch && !fail;
        state_n    = state;
        case (state)
            IDLE:    state_n = go ? RUN : IDLE;
            RUN:     state_n = last_op ? FLUSH : RUN;
            FLUSH:   state_n = DONE;
            default: state_n = go ? RUN : DONE;
        endcase
`ifdef SRAM_BIST_STOP_ON_FAIL_EN
        if (first_fail && busy) state_n = DONE;
`else
`endif
        issue = state_n == RUN;
    end

    // State register and registered SRAM command; reads carry their expected data on sram_din
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            elem       <= '0;
            ph         <= 1'b0;
            sram_we    <= 1'b0;
            sram_wmask <= 1'b0;
            sram_addr  <= '0;
            sram_din   <= '0;
        end else begin
            state      <= state_n;
            sram_we    <= issue && we_n;
            sram_wmask <= issue && we_n;
            if (issue) begin
                elem      <= elem_n;
                ph        <= ph_n;
                sram_addr <= addr_n;
                sram_din  <= {DATA_WIDTH{dbit_n}};
            end
        end
    end

    // One-deep compare pipeline and sticky first-failure capture
    always_ff @(posedge clk) begin
        if (rst) begin
            pv        <= 1'b0;
            pexp      <= '0;
            paddr     <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            pv    <= state == RUN && !sram_we;
            pexp  <= sram_din;
            paddr <= sram_addr;
            if (go) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_data <= '0;
            end else if (first_fail) begin
                fail      <= 1'b1;
                fail_addr <= paddr;
                fail_data <= sram_dout;
            end
        end
    end
endmodule
